// File: rtl/serial_word_loader_pkg.sv
// Shared types and width helpers for the serial word loader.
// No logic; compile-time definitions only.
// Imported by the top level and the shift-register sub-module.
package serial_word_loader_pkg;

    // FSM encoding: IDLE waits for the first bit, SHIFT holds a partial word.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Width needed to hold the values 0..n, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_word_loader_sipo_shift.sv
// Serial-in/parallel-out shift register, buff_len bits wide.
// Latency: par reflects a shifted bit one edge after shift_en.
// No backpressure; flush and clr clear the register and win over shift_en.
module sipo_shift #(
    parameter int buff_len  = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                shift_en,
    input  logic                flush,
    input  logic                sin,
    output logic [buff_len-1:0] par
);

    logic [buff_len-1:0] par_next;

    // Direction of the shift: MSB-first enters at the LSB, LSB-first enters at the MSB.
    generate
        if (MSB_FIRST) begin : g_msb
            assign par_next = {par[buff_len-2:0], sin};
        end else begin : g_lsb
            assign par_next = {sin, par[buff_len-1:1]};
        end
    endgenerate

    // Shift register update; clearing takes precedence over shifting.
    always_ff @(posedge clk) begin
        if (clr || flush) begin
            par <= '0;
        end else if (shift_en) begin
            par <= par_next;
        end
    end

endmodule

// File: rtl/serial_word_loader.sv
// Assembles a serial bit stream into buff_len-bit words and strobes load per word.
// Latency: load and x are visible the cycle after the last bit is sampled.
// No backpressure; abort and inter-bit timeout discard a partial word, x is kept.
module serial_word_loader
    import serial_word_loader_pkg::*;
#(
    parameter int buff_len  = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 16
) (
    input  logic                             clk,
    input  logic                             clr,
    input  logic                             sin,
    input  logic                             sin_valid,
    input  logic                             abort,
    output logic [buff_len-1:0]              x,
    output logic                             load,
    output logic                             busy,
    output logic [cnt_width(buff_len)-1:0]   bit_cnt,
    output logic                             timeout_err
);

    localparam int CW = cnt_width(buff_len);
    localparam int IW = cnt_width(TIMEOUT);

    localparam logic [CW-1:0] CNT_LAST  = CW'(buff_len - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '0;
    localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

    state_t              state;
    state_t              state_nxt;
    logic [IW-1:0]       idle_cnt;
    logic [IW-1:0]       idle_nxt;
    logic [CW-1:0]       cnt_nxt;
    logic                shift_en;
    logic                flush;
    logic                done;
    logic                tmo;
    logic [buff_len-1:0] par;
    logic [buff_len-1:0] word_full;

    sipo_shift #(
        .buff_len  (buff_len),
        .MSB_FIRST (MSB_FIRST)
    ) u_sipo (
        .clk      (clk),
        .clr      (clr),
        .shift_en (shift_en),
        .flush    (flush),
        .sin      (sin),
        .par      (par)
    );

    // The completed word includes the bit sampled on the completing edge, which
    // never enters the shift register (it is flushed on that edge instead).
    generate
        if (MSB_FIRST) begin : g_word_msb
            assign word_full = {par[buff_len-2:0], sin};
        end else begin : g_word_lsb
            assign word_full = {sin, par[buff_len-1:1]};
        end
    endgenerate

    assign busy = (state == ST_SHIFT);

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control; abort outranks completion and timeout.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        flush     = 1'b0;
        done      = 1'b0;
        tmo       = 1'b0;
        cnt_nxt   = bit_cnt;
        idle_nxt  = idle_cnt;
        if (abort) begin
            state_nxt = ST_IDLE;
            flush     = 1'b1;
            cnt_nxt   = '0;
            idle_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idle_nxt = '0;
                    if (sin_valid) begin
                        shift_en  = 1'b1;
                        cnt_nxt   = CNT_ONE;
                        state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sin_valid) begin
                        idle_nxt = '0;
                        if (bit_cnt == CNT_LAST) begin
                            done      = 1'b1;
                            flush     = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = ST_IDLE;
                        end else begin
                            shift_en = 1'b1;
                            cnt_nxt  = bit_cnt + CNT_ONE;
                        end
                    end else if (TIMEOUT > 0) begin
                        if (idle_cnt == IDLE_LAST) begin
                            tmo       = 1'b1;
                            flush     = 1'b1;
                            cnt_nxt   = '0;
                            idle_nxt  = '0;
                            state_nxt = ST_IDLE;
                        end else begin
                            idle_nxt = idle_cnt + IDLE_ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    flush     = 1'b1;
                    cnt_nxt   = '0;
                    idle_nxt  = '0;
                end
            endcase
        end
    end

    // Output and counter registers; x only moves on a completed word or clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            x           <= '0;
            load        <= 1'b0;
            timeout_err <= 1'b0;
            bit_cnt     <= '0;
            idle_cnt    <= '0;
        end else begin
            load        <= done;
            timeout_err <= tmo;
            bit_cnt     <= cnt_nxt;
            idle_cnt    <= idle_nxt;
            if (done) begin
                x <= word_full;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// Self-checking bench: two loaders (MSB-first and LSB-first) share one stimulus
// stream and are compared against a bit-queue reference model each cycle.
module tb_serial_word_loader;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       abort = 1'b0;

    logic [7:0] x_m, x_l;
    logic       load_m, load_l, busy_m, busy_l, terr_m, terr_l;
    logic [3:0] cnt_m, cnt_l;
    logic [7:0] buf_q;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int         bq[$];
    int         m_idle = 0;
    logic [7:0] m_xm = 8'h00;
    logic [7:0] m_xl = 8'h00;
    logic       m_load = 1'b0;
    logic       m_terr = 1'b0;

    always #5 clk = ~clk;

    serial_word_loader #(.buff_len(8), .MSB_FIRST(1'b1), .TIMEOUT(16)) dut_m (
        .clk(clk), .clr(clr), .sin(sin), .sin_valid(sin_valid), .abort(abort),
        .x(x_m), .load(load_m), .busy(busy_m), .bit_cnt(cnt_m), .timeout_err(terr_m)
    );

    serial_word_loader #(.buff_len(8), .MSB_FIRST(1'b0), .TIMEOUT(16)) dut_l (
        .clk(clk), .clr(clr), .sin(sin), .sin_valid(sin_valid), .abort(abort),
        .x(x_l), .load(load_l), .busy(busy_l), .bit_cnt(cnt_l), .timeout_err(terr_l)
    );

    // Downstream buffer register fed from x/load.
    always_ff @(posedge clk) begin
        if (clr) buf_q <= 8'h00;
        else if (load_m) buf_q <= x_m;
    end

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input logic b, input logic v, input logic a, input logic c);
        logic [7:0] wm, wl;
        if (c) begin
            bq.delete(); m_idle = 0; m_xm = 8'h00; m_xl = 8'h00; m_load = 1'b0; m_terr = 1'b0;
        end else if (a) begin
            bq.delete(); m_idle = 0; m_load = 1'b0; m_terr = 1'b0;
        end else if (v) begin
            bq.push_back(int'(b)); m_idle = 0; m_load = 1'b0; m_terr = 1'b0;
            if (bq.size() == 8) begin
                wm = 8'h00; wl = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    wm = wm | (8'(bq[i]) << (7 - i));
                    wl = wl | (8'(bq[i]) << i);
                end
                m_xm = wm; m_xl = wl; m_load = 1'b1;
                bq.delete();
            end
        end else begin
            m_load = 1'b0; m_terr = 1'b0;
            if (bq.size() > 0) begin
                m_idle++;
                if (m_idle == 16) begin
                    bq.delete(); m_idle = 0; m_terr = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic b, input logic v, input logic a, input logic c);
        clr = c; sin = b; sin_valid = v; abort = a;
        model_edge(b, v, a, c);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({x_m, load_m, busy_m, cnt_m, terr_m} !== 15'd0) begin
            failures++;
            $display("FAIL reset_m: x=%h load=%b busy=%b cnt=%0d terr=%b, want all zero", x_m, load_m, busy_m, cnt_m, terr_m);
        end
        checks++;
        if ({x_l, load_l, busy_l, cnt_l, terr_l} !== 15'd0) begin
            failures++;
            $display("FAIL reset_l: x=%h load=%b busy=%b cnt=%0d terr=%b, want all zero", x_l, load_l, busy_l, cnt_l, terr_l);
        end
    endtask

    task automatic test_single_word;
        logic [7:0] bits;
        bits = 8'b1100_0000;
        for (int i = 0; i < 8; i++) begin
            step(bits[7-i], 1'b1, 1'b0, 1'b0);
            if (i == 6) begin
                checks++;
                if (load_m !== 1'b0 || cnt_m !== 4'd7) begin
                    failures++;
                    $display("FAIL single_pre: load=%b cnt=%0d, want load=0 cnt=7", load_m, cnt_m);
                end
            end
        end
        checks++;
        if (load_m !== 1'b1 || x_m !== 8'hC0) begin
            failures++;
            $display("FAIL single_msb: load=%b x=%h, want load=1 x=c0", load_m, x_m);
        end
        checks++;
        if (load_l !== 1'b1 || x_l !== 8'h03) begin
            failures++;
            $display("FAIL single_lsb: load=%b x=%h, want load=1 x=03", load_l, x_l);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (load_m !== 1'b0 || load_l !== 1'b0 || buf_q !== 8'hC0 || cnt_m !== 4'd0) begin
            failures++;
            $display("FAIL single_post: load=%b/%b buf=%h cnt=%0d, want 0/0 c0 0", load_m, load_l, buf_q, cnt_m);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] bits;
        int          pulses;
        bits = {8'h04, 8'h0A};
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step(bits[15-i], 1'b1, 1'b0, 1'b0);
            checks++;
            if (load_m !== ((i == 7) || (i == 15)) || busy_m !== !((i == 7) || (i == 15))) begin
                failures++;
                $display("FAIL b2b_step%0d: load=%b busy=%b, want load=%b busy=%b", i, load_m, busy_m,
                         (i == 7) || (i == 15), !((i == 7) || (i == 15)));
            end
            if (load_m === 1'b1) pulses++;
            if (i == 7) begin
                checks++;
                if (x_m !== 8'h04) begin
                    failures++;
                    $display("FAIL b2b_word0: x=%h, want 04", x_m);
                end
            end
        end
        checks++;
        if (x_m !== 8'h0A || pulses != 2) begin
            failures++;
            $display("FAIL b2b_word1: x=%h pulses=%0d, want 0a and 2", x_m, pulses);
        end
    endtask

    task automatic test_timeout;
        logic [7:0] xprev;
        logic [7:0] bits;
        int         terr_seen;
        xprev = x_m;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (terr_m !== (i == 15) || terr_l !== (i == 15) || load_m !== 1'b0) begin
                failures++;
                $display("FAIL tmo_idle%0d: terr=%b/%b load=%b, want terr=%b load=0", i, terr_m, terr_l, load_m, i == 15);
            end
        end
        checks++;
        if (cnt_m !== 4'd0 || busy_m !== 1'b0 || x_m !== xprev) begin
            failures++;
            $display("FAIL tmo_state: cnt=%0d busy=%b x=%h, want 0 0 %h", cnt_m, busy_m, x_m, xprev);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (terr_m !== 1'b0) begin
            failures++;
            $display("FAIL tmo_pulse_width: terr=%b, want 0", terr_m);
        end
        // 15-cycle gap is tolerated
        bits = 8'b1011_1001;
        terr_seen = 0;
        for (int i = 0; i < 3; i++) step(bits[7-i], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (terr_m !== 1'b0) terr_seen++;
        end
        for (int i = 3; i < 8; i++) begin
            step(bits[7-i], 1'b1, 1'b0, 1'b0);
            if (terr_m !== 1'b0) terr_seen++;
        end
        checks++;
        if (load_m !== 1'b1 || x_m !== 8'hB9 || x_l !== 8'h9D || terr_seen != 0) begin
            failures++;
            $display("FAIL gap15: load=%b x=%h/%h terr_seen=%0d, want 1 b9/9d 0", load_m, x_m, x_l, terr_seen);
        end
    endtask

    task automatic test_abort_clr;
        logic [7:0] bits;
        bits = 8'h55;
        for (int i = 0; i < 8; i++) step(bits[7-i], 1'b1, 1'b0, 1'b0);
        checks++;
        if (x_m !== 8'h55 || x_l !== 8'hAA || load_m !== 1'b1) begin
            failures++;
            $display("FAIL abort_setup: x=%h/%h load=%b, want 55/aa 1", x_m, x_l, load_m);
        end
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (load_m !== 1'b0 || x_m !== 8'h55 || cnt_m !== 4'd0 || busy_m !== 1'b0) begin
            failures++;
            $display("FAIL abort_last: load=%b x=%h cnt=%0d busy=%b, want 0 55 0 0", load_m, x_m, cnt_m, busy_m);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (cnt_m !== 4'd0 || x_m !== 8'h00 || x_l !== 8'h00 || load_m !== 1'b0 || busy_m !== 1'b0) begin
            failures++;
            $display("FAIL clr_mid: cnt=%0d x=%h/%h load=%b busy=%b, want 0 00/00 0 0", cnt_m, x_m, x_l, load_m, busy_m);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        int   vld_pct;
        logic b, v, a, c;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) vld_pct = ($urandom_range(0, 1) == 1) ? 90 : 20;
            b = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 99) < vld_pct);
            a = ($urandom_range(0, 59) == 0);
            c = ($urandom_range(0, 299) == 0);
            step(b, v, a, c);
            checks++;
            if (x_m !== m_xm || x_l !== m_xl || load_m !== m_load || load_l !== m_load ||
                terr_m !== m_terr || terr_l !== m_terr || busy_m !== (bq.size() > 0) ||
                busy_l !== (bq.size() > 0) || cnt_m !== 4'(bq.size()) || cnt_l !== 4'(bq.size())) begin
                failures++;
                $display("FAIL rand_cyc%0d: x=%h/%h load=%b/%b terr=%b/%b busy=%b/%b cnt=%0d/%0d, want x=%h/%h load=%b terr=%b busy=%b cnt=%0d",
                         n, x_m, x_l, load_m, load_l, terr_m, terr_l, busy_m, busy_l, cnt_m, cnt_l,
                         m_xm, m_xl, m_load, m_terr, bq.size() > 0, bq.size());
            end
            checks++;
            if ((load_m & terr_m) !== 1'b0) begin
                failures++;
                $display("FAIL rand_excl%0d: load=%b terr=%b, want not both", n, load_m, terr_m);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_timeout();
        test_abort_clr();
        test_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
